// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : MIPS execute stage with operand forwarding and EX/MEM latch
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_dato_1,
   input  logic [DATA_W-1:0] i_dato_2,
   input  logic [REG_W-1:0]  i_rs,
   input  logic [REG_W-1:0]  i_rt,
   input  logic [REG_W-1:0]  i_rd,
   input  logic [DATA_W-1:0] i_ext_imm,
   input  logic              i_reg_dst,
   input  logic              i_alu_src,
   input  logic [2:0]        i_alu_op,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_mem_to_reg,
   input  logic              i_reg_write,
   input  logic [REG_W-1:0]  i_wb_rd,
   input  logic              i_wb_reg_write,
   input  logic [DATA_W-1:0] i_wb_data,
   output logic [DATA_W-1:0] o_alu_result,
   output logic [DATA_W-1:0] o_write_data,
   output logic [REG_W-1:0]  o_write_reg,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic              o_mem_to_reg,
   output logic              o_reg_write,
   output logic              o_overflow
);

   localparam logic [5:0] c_F_SLL  = 6'h00;
   localparam logic [5:0] c_F_SRL  = 6'h02;
   localparam logic [5:0] c_F_SRA  = 6'h03;
   localparam logic [5:0] c_F_SLLV = 6'h04;
   localparam logic [5:0] c_F_SRLV = 6'h06;
   localparam logic [5:0] c_F_SRAV = 6'h07;
   localparam logic [5:0] c_F_ADD  = 6'h20;
   localparam logic [5:0] c_F_ADDU = 6'h21;
   localparam logic [5:0] c_F_SUB  = 6'h22;
   localparam logic [5:0] c_F_SUBU = 6'h23;
   localparam logic [5:0] c_F_AND  = 6'h24;
   localparam logic [5:0] c_F_OR   = 6'h25;
   localparam logic [5:0] c_F_XOR  = 6'h26;
   localparam logic [5:0] c_F_NOR  = 6'h27;
   localparam logic [5:0] c_F_SLT  = 6'h2A;
   localparam logic [5:0] c_F_SLTU = 6'h2B;

   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [REG_W-1:0]  wreg_q, wreg_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic              reg_write_q, reg_write_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] op_a, op_b, alu_b, logic_b, sum, diff, alu_res;
   logic              add_ovf, sub_ovf, alu_ovf, bad_funct;
   logic [5:0]        funct;
   logic [4:0]        shamt, vshamt;

   // Loads are excluded from EX/MEM forwarding: their data is not known until MEM.
   always_comb begin
      if (reg_write_q && !mem_to_reg_q && (wreg_q != '0) && (wreg_q == i_rs))
         op_a = result_q;
      else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_rs))
         op_a = i_wb_data;
      else
         op_a = i_dato_1;

      if (reg_write_q && !mem_to_reg_q && (wreg_q != '0) && (wreg_q == i_rt))
         op_b = result_q;
      else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_rt))
         op_b = i_wb_data;
      else
         op_b = i_dato_2;
   end

   assign alu_b   = i_alu_src ? i_ext_imm : op_b;
   assign logic_b = i_alu_src ? {16'h0, i_ext_imm[15:0]} : op_b;
   assign sum     = op_a + alu_b;
   assign diff    = op_a - alu_b;
   assign add_ovf = (op_a[DATA_W-1] == alu_b[DATA_W-1]) && (sum[DATA_W-1]  != op_a[DATA_W-1]);
   assign sub_ovf = (op_a[DATA_W-1] != alu_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
   assign funct   = i_ext_imm[5:0];
   assign shamt   = i_ext_imm[10:6];
   assign vshamt  = op_a[4:0];

   always_comb begin
      alu_res   = '0;
      alu_ovf   = 1'b0;
      bad_funct = 1'b0;
      case (i_alu_op)
         3'b000: begin
            alu_res = sum;
            // Address generation for lw/sw shares this op and must never trap.
            alu_ovf = add_ovf && !(i_mem_read || i_mem_write);
         end
         3'b001: begin
            alu_res = diff;
            alu_ovf = sub_ovf;
         end
         3'b010: begin
            case (funct)
               c_F_ADD:  begin alu_res = sum;  alu_ovf = add_ovf; end
               c_F_ADDU: alu_res = sum;
               c_F_SUB:  begin alu_res = diff; alu_ovf = sub_ovf; end
               c_F_SUBU: alu_res = diff;
               c_F_AND:  alu_res = op_a & alu_b;
               c_F_OR:   alu_res = op_a | alu_b;
               c_F_XOR:  alu_res = op_a ^ alu_b;
               c_F_NOR:  alu_res = ~(op_a | alu_b);
               c_F_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
               c_F_SLTU: alu_res = {{(DATA_W-1){1'b0}}, op_a < alu_b};
               c_F_SLL:  alu_res = alu_b << shamt;
               c_F_SRL:  alu_res = alu_b >> shamt;
               c_F_SRA:  alu_res = $unsigned($signed(alu_b) >>> shamt);
               c_F_SLLV: alu_res = alu_b << vshamt;
               c_F_SRLV: alu_res = alu_b >> vshamt;
               c_F_SRAV: alu_res = $unsigned($signed(alu_b) >>> vshamt);
               default:  bad_funct = 1'b1;
            endcase
         end
         3'b011:  alu_res = op_a & logic_b;
         3'b100:  alu_res = op_a | logic_b;
         3'b101:  alu_res = op_a ^ logic_b;
         3'b110:  alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
         default: alu_res = {i_ext_imm[15:0], 16'h0};
      endcase
   end

   always_comb begin
      result_d     = result_q;
      wdata_d      = wdata_q;
      wreg_d       = wreg_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      reg_write_d  = reg_write_q;
      ovf_d        = ovf_q;
      if (!i_stall) begin
         if (i_flush) begin
            result_d     = '0;
            wdata_d      = '0;
            wreg_d       = '0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
            ovf_d        = 1'b0;
         end else begin
            result_d     = alu_res;
            wdata_d      = op_b;
            wreg_d       = i_reg_dst ? i_rd : i_rt;
            mem_read_d   = i_mem_read;
            mem_write_d  = i_mem_write;
            mem_to_reg_d = i_mem_to_reg;
            reg_write_d  = i_reg_write && !alu_ovf && !bad_funct;
            ovf_d        = alu_ovf;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         result_q     <= '0;
         wdata_q      <= '0;
         wreg_q       <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         result_q     <= result_d;
         wdata_q      <= wdata_d;
         wreg_q       <= wreg_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         reg_write_q  <= reg_write_d;
         ovf_q        <= ovf_d;
      end
   end

   assign o_alu_result = result_q;
   assign o_write_data = wdata_q;
   assign o_write_reg  = wreg_q;
   assign o_mem_read   = mem_read_q;
   assign o_mem_write  = mem_write_q;
   assign o_mem_to_reg = mem_to_reg_q;
   assign o_reg_write  = reg_write_q;
   assign o_overflow   = ovf_q;

endmodule

`default_nettype wire
